// File: rtl/scheduler_pkg.sv
// Shared definitions for the round-robin program scheduler.
// Holds the scheduler state encoding and the quantum loaded at reset.
// Also used by the program counter and the debug display.
package scheduler_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StSelect = 2'd2,
        StSwitch = 2'd3
    } sched_state_t;

    localparam int unsigned DEFAULT_QUANTUM = 1000;

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority encoder: finds the first set bit of `active`.
// The search order is cur+1, cur+2, ... with wrap-around, and `cur` itself is tried last.
// Ports:
//   active : request/eligibility mask
//   cur    : index of the current holder
//   found  : some bit of `active` is set
//   next   : index that was chosen (equals `cur` when nothing is found)
module rr_picker #(
    parameter int unsigned WIDTH = 4,
    localparam int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] active,
    input  logic [IDX_W-1:0] cur,
    output logic             found,
    output logic [IDX_W-1:0] next
);

    logic [IDX_W-1:0] idx;

    // WIDTH is a power of two, so truncating cur+i wraps around naturally.
    // The last step (i == WIDTH) lands on cur itself.
    always_comb begin
        found = 1'b0;
        next  = cur;
        idx   = cur;
        for (int unsigned i = 1; i <= WIDTH; i++) begin
            idx = cur + IDX_W'(i);
            if (!found && active[idx]) begin
                found = 1'b1;
                next  = idx;
            end
        end
    end

endmodule

// File: rtl/program_scheduler.sv
// Round-robin time-slice scheduler for the multiprogrammed CPU.
// It holds one saved PC and one active flag per program slot.
// It counts retired instructions against a programmable quantum.
// On quantum expiry, yield or program end it picks the next active program
// and asks the program counter to switch to it.
// Ports:
//   clock, reset_n           : system clock, synchronous active-low reset
//   tick                     : one strobe per retired instruction
//   defquantum/quantum_value : load a new quantum length (0 is treated as 1)
//   cur_pc                   : PC of the running program, saved on yield/expiry
//   end_program, yield       : running program terminates / gives up its slice
//   start_valid/pc/ready     : load a new program into the lowest free slot
//   switch_valid/pc/ack      : context-switch request to the program counter
//   cur_program              : slot of the running program
//   all_done                 : no program is running or pending
module program_scheduler
    import scheduler_pkg::sched_state_t, scheduler_pkg::StIdle, scheduler_pkg::StRun,
           scheduler_pkg::StSelect, scheduler_pkg::StSwitch;
#(
    parameter int unsigned NUM_PROGRAMS    = 4,
    parameter int unsigned QUANTUM_W       = 16,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DEFAULT_QUANTUM = scheduler_pkg::DEFAULT_QUANTUM,
    localparam int unsigned IDX_W          = $clog2(NUM_PROGRAMS)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 tick,
    input  logic                 defquantum,
    input  logic [QUANTUM_W-1:0] quantum_value,
    input  logic [ADDR_W-1:0]    cur_pc,
    input  logic                 end_program,
    input  logic                 yield,
    input  logic                 start_valid,
    input  logic [ADDR_W-1:0]    start_pc,
    output logic                 start_ready,
    output logic                 switch_valid,
    output logic [ADDR_W-1:0]    switch_pc,
    input  logic                 switch_ack,
    output logic [IDX_W-1:0]     cur_program,
    output logic                 all_done
);

    sched_state_t             state;
    logic [NUM_PROGRAMS-1:0]  active;
    logic [ADDR_W-1:0]        pc_table [NUM_PROGRAMS];
    logic [IDX_W-1:0]         cur;
    logic [QUANTUM_W-1:0]     count;
    logic [QUANTUM_W-1:0]     quantum;

    logic                     start_fire;
    logic                     expire;
    logic                     free_found;
    logic [IDX_W-1:0]         free_slot;
    logic                     pick_found;
    logic [IDX_W-1:0]         pick_next;

    rr_picker #(
        .WIDTH (NUM_PROGRAMS)
    ) u_picker (
        .active (active),
        .cur    (cur),
        .found  (pick_found),
        .next   (pick_next)
    );

    // Lowest-index inactive slot receives a newly started program.
    always_comb begin
        free_found = 1'b0;
        free_slot  = '0;
        for (int unsigned i = 0; i < NUM_PROGRAMS; i++) begin
            if (!free_found && !active[i]) begin
                free_found = 1'b1;
                free_slot  = IDX_W'(i);
            end
        end
    end

    // Starts are blocked in SELECT so the picker sees a stable mask.
    assign start_ready = free_found && (state != StSelect);
    assign start_fire  = start_valid && start_ready;
    assign expire      = tick && (count == quantum - 1'b1);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= StIdle;
            active  <= '0;
            cur     <= '0;
            count   <= '0;
            quantum <= QUANTUM_W'(DEFAULT_QUANTUM);
            for (int unsigned i = 0; i < NUM_PROGRAMS; i++) begin
                pc_table[i] <= '0;
            end
        end else begin
            if (defquantum) begin
                quantum <= (quantum_value == '0) ? QUANTUM_W'(1) : quantum_value;
            end

            // The free slot is never `cur` while a program runs, so the start load
            // and the clear/save of `cur` below never collide.
            if (start_fire) begin
                pc_table[free_slot] <= start_pc;
                active[free_slot]   <= 1'b1;
            end

            case (state)
                StIdle: begin
                    if (start_fire) begin
                        state <= StSelect;
                    end
                end
                StRun: begin
                    if (end_program) begin
                        active[cur] <= 1'b0;
                        state       <= StSelect;
                    end else if (yield || expire) begin
                        pc_table[cur] <= cur_pc;
                        state         <= StSelect;
                    end else if (tick) begin
                        count <= count + 1'b1;
                    end
                end
                StSelect: begin
                    if (pick_found) begin
                        cur   <= pick_next;
                        state <= StSwitch;
                    end else begin
                        state <= StIdle;
                    end
                end
                StSwitch: begin
                    if (switch_ack) begin
                        count <= '0;
                        state <= StRun;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign switch_valid = (state == StSwitch);
    assign switch_pc    = pc_table[cur];
    assign cur_program  = cur;
    assign all_done     = (state == StIdle);

endmodule

// File: tb/tb_program_scheduler.sv
// Directed self-checking bench for program_scheduler.
module tb_program_scheduler;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        tick;
    logic        defquantum;
    logic [15:0] quantum_value;
    logic [31:0] cur_pc;
    logic        end_program;
    logic        yield;
    logic        start_valid;
    logic [31:0] start_pc;
    logic        start_ready;
    logic        switch_valid;
    logic [31:0] switch_pc;
    logic        switch_ack;
    logic [1:0]  cur_program;
    logic        all_done;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    program_scheduler dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .tick          (tick),
        .defquantum    (defquantum),
        .quantum_value (quantum_value),
        .cur_pc        (cur_pc),
        .end_program   (end_program),
        .yield         (yield),
        .start_valid   (start_valid),
        .start_pc      (start_pc),
        .start_ready   (start_ready),
        .switch_valid  (switch_valid),
        .switch_pc     (switch_pc),
        .switch_ack    (switch_ack),
        .cur_program   (cur_program),
        .all_done      (all_done)
    );

    task automatic do_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        tick = 0; defquantum = 0; quantum_value = '0; cur_pc = '0;
        end_program = 0; yield = 0; start_valid = 0; start_pc = '0; switch_ack = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset_n = 0;
        do_cycle();
        do_cycle();
        reset_n = 1;
    endtask

    task automatic set_quantum(input logic [15:0] v);
        defquantum = 1; quantum_value = v;
        do_cycle();
        defquantum = 0;
    endtask

    task automatic start_prog(input logic [31:0] pc);
        start_valid = 1; start_pc = pc;
        do_cycle();
        start_valid = 0;
    endtask

    task automatic ack();
        switch_ack = 1;
        do_cycle();
        switch_ack = 0;
    endtask

    // Event in RUN, then the SELECT cycle; returns with the switch visible.
    task automatic fire(input logic e, input logic y, input logic t, input logic [31:0] pc);
        end_program = e; yield = y; tick = t; cur_pc = pc;
        do_cycle();
        end_program = 0; yield = 0; tick = 0;
        do_cycle();
    endtask

    // Slots 0..3 hold 0x100..0x400; slot 0 ends up running.
    task automatic load_four();
        start_prog(32'h100);
        do_cycle();
        start_prog(32'h200);
        start_prog(32'h300);
        start_prog(32'h400);
        ack();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 0;
        do_cycle();
        checks++; if (switch_valid !== 1'b0) begin errors++; $display("FAIL reset_switch_valid: got %b expected 0", switch_valid); end
        checks++; if (switch_pc !== 32'h0) begin errors++; $display("FAIL reset_switch_pc: got %h expected 0", switch_pc); end
        checks++; if (cur_program !== 2'd0) begin errors++; $display("FAIL reset_cur_program: got %0d expected 0", cur_program); end
        checks++; if (all_done !== 1'b1) begin errors++; $display("FAIL reset_all_done: got %b expected 1", all_done); end
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready: got %b expected 1", start_ready); end
        reset_n = 1;
        do_cycle();
        checks++; if (all_done !== 1'b1) begin errors++; $display("FAIL idle_all_done: got %b expected 1", all_done); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        defquantum = 1; quantum_value = 16'd3;
        start_prog(32'h10);
        defquantum = 0;
        checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL rr_ready_in_select: got %b expected 0", start_ready); end
        checks++; if (switch_valid !== 1'b0) begin errors++; $display("FAIL rr_no_early_switch: got %b expected 0", switch_valid); end
        do_cycle();
        checks++; if (switch_valid !== 1'b1) begin errors++; $display("FAIL rr_first_valid: got %b expected 1", switch_valid); end
        checks++; if (switch_pc !== 32'h10) begin errors++; $display("FAIL rr_first_pc: got %h expected 00000010", switch_pc); end
        checks++; if (cur_program !== 2'd0) begin errors++; $display("FAIL rr_first_slot: got %0d expected 0", cur_program); end
        checks++; if (all_done !== 1'b0) begin errors++; $display("FAIL rr_all_done_busy: got %b expected 0", all_done); end
        start_prog(32'h40);
        ack();
        tick = 1; cur_pc = 32'h1234;
        do_cycle(); do_cycle();
        checks++; if (switch_valid !== 1'b0) begin errors++; $display("FAIL rr_two_ticks: got %b expected 0", switch_valid); end
        do_cycle();
        tick = 0;
        do_cycle();
        checks++; if (switch_pc !== 32'h40) begin errors++; $display("FAIL rr_second_pc: got %h expected 00000040", switch_pc); end
        checks++; if (cur_program !== 2'd1) begin errors++; $display("FAIL rr_second_slot: got %0d expected 1", cur_program); end
        ack();
        tick = 1; cur_pc = 32'h2222;
        do_cycle(); do_cycle(); do_cycle();
        tick = 0;
        do_cycle();
        checks++; if (switch_pc !== 32'h1234) begin errors++; $display("FAIL rr_saved_pc: got %h expected 00001234", switch_pc); end
        checks++; if (cur_program !== 2'd0) begin errors++; $display("FAIL rr_wrap_slot: got %0d expected 0", cur_program); end
    endtask

    task automatic test_end_program();
        apply_reset();
        load_four();
        checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL end_full_ready: got %b expected 0", start_ready); end
        fire(0, 1, 0, 32'h110); ack();
        fire(0, 1, 0, 32'h210); ack();
        fire(1, 0, 0, 32'h0);
        checks++; if (cur_program !== 2'd3) begin errors++; $display("FAIL end_skip_slot: got %0d expected 3", cur_program); end
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL end_freed_ready: got %b expected 1", start_ready); end
        ack();
        fire(0, 1, 0, 32'h410); ack();
        fire(0, 1, 0, 32'h120);
        checks++; if (switch_pc !== 32'h210 || cur_program !== 2'd1) begin errors++; $display("FAIL end_slot1_run: got slot %0d pc %h expected slot 1 pc 00000210", cur_program, switch_pc); end
        ack();
        fire(1, 0, 0, 32'h0);
        checks++; if (switch_pc !== 32'h410 || cur_program !== 2'd3) begin errors++; $display("FAIL end_mask_1001: got slot %0d pc %h expected slot 3 pc 00000410", cur_program, switch_pc); end
        ack();
        fire(1, 0, 0, 32'h0);
        checks++; if (switch_pc !== 32'h120 || cur_program !== 2'd0) begin errors++; $display("FAIL end_mask_0001: got slot %0d pc %h expected slot 0 pc 00000120", cur_program, switch_pc); end
        ack();
        fire(1, 0, 0, 32'h0);
        checks++; if (all_done !== 1'b1 || switch_valid !== 1'b0) begin errors++; $display("FAIL end_to_idle: got all_done %b switch_valid %b expected 1 0", all_done, switch_valid); end
    endtask

    task automatic test_event_priority();
        apply_reset();
        set_quantum(16'd2);
        start_prog(32'h10);
        do_cycle();
        start_prog(32'h20);
        ack();
        tick = 1; do_cycle(); tick = 0;
        fire(0, 1, 1, 32'h55);
        checks++; if (switch_pc !== 32'h20 || cur_program !== 2'd1) begin errors++; $display("FAIL prio_yield_expire: got slot %0d pc %h expected slot 1 pc 00000020", cur_program, switch_pc); end
        ack();
        do_cycle(); do_cycle();
        checks++; if (switch_valid !== 1'b0) begin errors++; $display("FAIL prio_single_switch: got %b expected 0", switch_valid); end
        fire(0, 1, 0, 32'h66);
        checks++; if (switch_pc !== 32'h55) begin errors++; $display("FAIL prio_one_save: got %h expected 00000055", switch_pc); end
        ack();
        fire(1, 1, 0, 32'h77);
        checks++; if (switch_pc !== 32'h66 || cur_program !== 2'd1) begin errors++; $display("FAIL prio_end_yield: got slot %0d pc %h expected slot 1 pc 00000066", cur_program, switch_pc); end
        ack();
        fire(0, 1, 0, 32'h88);
        checks++; if (switch_pc !== 32'h88 || cur_program !== 2'd1) begin errors++; $display("FAIL prio_reselect: got slot %0d pc %h expected slot 1 pc 00000088", cur_program, switch_pc); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        load_four();
        start_valid = 1; start_pc = 32'h999;
        do_cycle(); do_cycle(); do_cycle();
        checks++; if (start_ready !== 1'b0 || switch_valid !== 1'b0) begin errors++; $display("FAIL full_hold: got ready %b valid %b expected 0 0", start_ready, switch_valid); end
        end_program = 1;
        do_cycle();
        end_program = 0;
        checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL full_select_block: got %b expected 0", start_ready); end
        do_cycle();
        checks++; if (start_ready !== 1'b1 || cur_program !== 2'd1) begin errors++; $display("FAIL full_freed: got ready %b slot %0d expected 1 1", start_ready, cur_program); end
        do_cycle();
        start_valid = 0;
        checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL full_refilled: got %b expected 0", start_ready); end
        ack();
        fire(0, 1, 0, 32'h201); ack();
        fire(0, 1, 0, 32'h301); ack();
        fire(0, 1, 0, 32'h401);
        checks++; if (switch_pc !== 32'h999 || cur_program !== 2'd0) begin errors++; $display("FAIL full_lowest_slot: got slot %0d pc %h expected slot 0 pc 00000999", cur_program, switch_pc); end
    endtask

    task automatic test_zero_quantum_stall();
        apply_reset();
        set_quantum(16'd0);
        start_prog(32'h10);
        do_cycle();
        start_prog(32'h20);
        ack();
        tick = 1; cur_pc = 32'hA0;
        do_cycle(); do_cycle();
        checks++; if (switch_valid !== 1'b1 || switch_pc !== 32'h20 || cur_program !== 2'd1) begin errors++; $display("FAIL zq_one_tick: got valid %b slot %0d pc %h expected 1 1 00000020", switch_valid, cur_program, switch_pc); end
        for (int i = 0; i < 5; i++) begin
            do_cycle();
            checks++; if (switch_valid !== 1'b1 || switch_pc !== 32'h20) begin errors++; $display("FAIL zq_stall_%0d: got valid %b pc %h expected 1 00000020", i, switch_valid, switch_pc); end
        end
        ack();
        cur_pc = 32'hB0;
        do_cycle(); do_cycle();
        checks++; if (switch_pc !== 32'hA0 || cur_program !== 2'd0) begin errors++; $display("FAIL zq_next_tick: got slot %0d pc %h expected slot 0 pc 000000a0", cur_program, switch_pc); end
        tick = 0;
    endtask

    task automatic test_reset_mid_switch();
        reset_n = 0;
        do_cycle();
        checks++; if (switch_valid !== 1'b0 || all_done !== 1'b1) begin errors++; $display("FAIL midrst_outputs: got valid %b all_done %b expected 0 1", switch_valid, all_done); end
        checks++; if (switch_pc !== 32'h0 || cur_program !== 2'd0 || start_ready !== 1'b1) begin errors++; $display("FAIL midrst_state: got pc %h slot %0d ready %b expected 0 0 1", switch_pc, cur_program, start_ready); end
        reset_n = 1;
        start_prog(32'h300);
        do_cycle();
        checks++; if (switch_valid !== 1'b1 || switch_pc !== 32'h300) begin errors++; $display("FAIL midrst_start: got valid %b pc %h expected 1 00000300", switch_valid, switch_pc); end
        ack();
        tick = 1; cur_pc = 32'h3F0;
        repeat (999) do_cycle();
        tick = 0;
        do_cycle();
        checks++; if (switch_valid !== 1'b0) begin errors++; $display("FAIL midrst_999_ticks: got %b expected 0", switch_valid); end
        tick = 1;
        do_cycle();
        tick = 0;
        do_cycle();
        checks++; if (switch_valid !== 1'b1 || switch_pc !== 32'h3F0) begin errors++; $display("FAIL midrst_1000_ticks: got valid %b pc %h expected 1 000003f0", switch_valid, switch_pc); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_end_program();
        test_event_priority();
        test_back_to_back();
        test_zero_quantum_stall();
        test_reset_mid_switch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
